// File: rtl/mem_port_arbiter.sv
// Shares one single-ported external memory between the fetch and data ports.
// Data requests win; a one-entry instruction buffer absorbs repeated fetches.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_stall,
    input  logic              d_read_en,
    input  logic              d_write_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        D_BUSY,
        I_BUSY,
        D_DONE
    } state_t;

    state_t state, state_nx;

    logic              ibuf_valid;
    logic [ADDR_W-1:0] ibuf_pc;
    logic [DATA_W-1:0] ibuf_data;

    logic dreq, hit;
    logic issue_d, issue_i, d_ack, i_ack;

    assign dreq     = d_read_en | d_write_en;
    assign hit      = ibuf_valid && (ibuf_pc == if_pc);
    assign if_stall = !hit;
    assign if_instr = ibuf_data;
    assign d_stall  = dreq && (state != D_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        issue_d  = 1'b0;
        issue_i  = 1'b0;
        d_ack    = 1'b0;
        i_ack    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dreq) begin
                    issue_d  = 1'b1;
                    state_nx = D_BUSY;
                end else if (!hit) begin
                    issue_i  = 1'b1;
                    state_nx = I_BUSY;
                end
            end
            D_BUSY: begin
                if (mem_ack) begin
                    d_ack    = 1'b1;
                    state_nx = D_DONE;
                end
            end
            I_BUSY: begin
                if (mem_ack) begin
                    i_ack    = 1'b1;
                    state_nx = IDLE;
                end
            end
            D_DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ibuf_valid <= 1'b0;
            ibuf_pc    <= '0;
            ibuf_data  <= '0;
            d_rdata    <= '0;
        end else begin
            if (issue_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_write_en;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (issue_i) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_pc;
            end
            if (d_ack) begin
                mem_req <= 1'b0;
                if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end else if (mem_addr == ibuf_pc) begin
                    // a store over the buffered instruction makes it stale
                    ibuf_valid <= 1'b0;
                end
            end
            if (i_ack) begin
                mem_req    <= 1'b0;
                ibuf_valid <= 1'b1;
                ibuf_pc    <= mem_addr;
                ibuf_data  <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory transactions and
// load results are queued by the stimulus and checked by output monitors.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_stall;
    logic        d_read_en;
    logic        d_write_en;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] rd_q[$];
    txn_t        cur_e;
    logic [31:0] mem_m [logic [31:0]];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 0;
    int cnt   = 0;
    int rise_cyc = 0;
    int dd_cyc   = 0;
    int n;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_stall  (if_stall),
        .d_read_en (d_read_en),
        .d_write_en(d_write_en),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_txn(input logic we, input logic [31:0] a,
                           input logic [31:0] wd);
        txn_t t;
        t.we = we;
        t.addr = a;
        t.wdata = wd;
        exp_q.push_back(t);
    endtask

    task automatic count_if(output int c);
        c = 0;
        @(negedge clk);
        while (if_stall && c < 40) begin
            c++;
            @(negedge clk);
        end
    endtask

    task automatic count_d(output int c);
        c = 0;
        @(negedge clk);
        while (d_stall && c < 40) begin
            c++;
            @(negedge clk);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // memory model: ack L cycles after mem_req is first seen
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (!mem_req) begin
                cnt = 0;
            end else if (cnt >= lat) begin
                mem_ack = 1'b1;
                if (mem_we) mem_m[mem_addr] = mem_wdata;
                else mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
            end else begin
                cnt++;
            end
        end
    end

    // transaction monitor
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev) begin
                rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL txn_unexpected: got addr %h we %b expected none",
                             mem_addr, mem_we);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk("txn_we", {31'b0, mem_we}, {31'b0, cur_e.we});
                    chk("txn_addr", mem_addr, cur_e.addr);
                    if (cur_e.we) chk("txn_wdata", mem_wdata, cur_e.wdata);
                end
            end else if (mem_req && prev) begin
                chk("txn_hold_addr", mem_addr, cur_e.addr);
                chk("txn_hold_we", {31'b0, mem_we}, {31'b0, cur_e.we});
            end
            prev = mem_req;
        end
    end

    // data completion monitor: the cycle a data op is released
    initial begin
        forever begin
            @(negedge clk);
            if ((d_read_en || d_write_en) && !d_stall) begin
                dd_cyc = cyc;
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL d_done_unexpected: got rdata %h expected none", d_rdata);
                end else begin
                    chk("d_rdata", d_rdata, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        if_pc = 32'h0;
        d_read_en = 1'b0;
        d_write_en = 1'b0;
        d_addr = 32'h0;
        d_wdata = 32'h0;
        mem_m[32'h0]   = 32'h00000013;
        mem_m[32'h40]  = 32'h8C220004;
        mem_m[32'h44]  = 32'h11111111;
        mem_m[32'h48]  = 32'h22222222;
        mem_m[32'h100] = 32'hDEADBEEF;
        mem_m[32'h104] = 32'hCAFEF00D;
        lat = 3;

        // reset values, then reset dropped in the middle of a fetch
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_if_stall", {31'b0, if_stall}, 32'h1);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        step();
        reset = 1'b1;
        exp_txn(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rel_mem_req_lo", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        chk("rel_mem_req_hi", {31'b0, mem_req}, 32'h1);
        chk("rel_mem_addr", mem_addr, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("async_mem_req", {31'b0, mem_req}, 32'h0);
        chk("async_if_stall", {31'b0, if_stall}, 32'h1);
        lat = 0;
        step();
        reset = 1'b1;
        exp_txn(1'b0, 32'h0, 32'h0);
        count_if(n);
        chk("fetch0_stall_cycles", n, 2);
        chk("fetch0_instr", if_instr, 32'h00000013);

        // fetch miss at 0x40 with two wait cycles
        lat = 2;
        step();
        if_pc = 32'h40;
        exp_txn(1'b0, 32'h40, 32'h0);
        count_if(n);
        chk("fetch40_stall_cycles", n, 4);
        chk("fetch40_instr", if_instr, 32'h8C220004);
        @(negedge clk);
        chk("fetch40_no_rereq", {31'b0, mem_req}, 32'h0);
        chk("fetch40_hit", {31'b0, if_stall}, 32'h0);

        // load with zero wait
        lat = 0;
        step();
        d_read_en = 1'b1;
        d_addr = 32'h100;
        exp_txn(1'b0, 32'h100, 32'h0);
        rd_q.push_back(32'hDEADBEEF);
        count_d(n);
        chk("load_stall_cycles", n, 2);
        step();
        d_read_en = 1'b0;

        // store and fetch miss together: store goes first
        step();
        d_write_en = 1'b1;
        d_addr = 32'h200;
        d_wdata = 32'h5;
        if_pc = 32'h44;
        exp_txn(1'b1, 32'h200, 32'h5);
        exp_txn(1'b0, 32'h44, 32'h0);
        rd_q.push_back(32'hDEADBEEF);
        count_d(n);
        chk("store_stall_cycles", n, 2);
        step();
        d_write_en = 1'b0;
        count_if(n);
        chk("fetch44_after_done", (rise_cyc >= dd_cyc + 2) ? 32'h1 : 32'h0, 32'h1);
        chk("fetch44_instr", if_instr, 32'h11111111);
        chk("store_mem_written", mem_m[32'h200], 32'h5);

        // store over the buffered instruction forces a refetch
        step();
        if_pc = 32'h40;
        exp_txn(1'b0, 32'h40, 32'h0);
        count_if(n);
        chk("fetch40b_stall_cycles", n, 2);
        chk("fetch40b_instr", if_instr, 32'h8C220004);
        lat = 1;
        step();
        d_write_en = 1'b1;
        d_addr = 32'h40;
        d_wdata = 32'hABCD0001;
        exp_txn(1'b1, 32'h40, 32'hABCD0001);
        exp_txn(1'b0, 32'h40, 32'h0);
        rd_q.push_back(32'hDEADBEEF);
        count_d(n);
        chk("smc_stall_cycles", n, 3);
        chk("smc_if_stall", {31'b0, if_stall}, 32'h1);
        step();
        d_write_en = 1'b0;
        count_if(n);
        chk("smc_refetch_cycles", n, 3);
        chk("smc_refetch_instr", if_instr, 32'hABCD0001);

        // load arriving during an in-flight fetch waits for it
        lat = 3;
        step();
        if_pc = 32'h48;
        exp_txn(1'b0, 32'h48, 32'h0);
        exp_txn(1'b0, 32'h104, 32'h0);
        rd_q.push_back(32'hCAFEF00D);
        step();
        step();
        d_read_en = 1'b1;
        d_addr = 32'h104;
        count_d(n);
        chk("ibusy_wait_stall_cycles", n, 8);
        chk("ibusy_fetch_done", {31'b0, if_stall}, 32'h0);
        chk("ibusy_fetch_instr", if_instr, 32'h22222222);
        step();
        d_read_en = 1'b0;

        repeat (4) @(negedge clk);
        chk("txn_queue_empty", exp_q.size(), 0);
        chk("rd_queue_empty", rd_q.size(), 0);
        chk("final_d_rdata", d_rdata, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
